// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for a KGP-RISC-style datapath.
// One explicit state register drives all control outputs. Every output is registered and
// presented in the same cycle as the state it belongs to. Memory accesses use a
// variable-latency handshake with an optional ack timeout.
// Optional feature macro: ILLEGAL_TRAP_EN. When defined, an illegal opcode halts the unit
// until INT. When undefined, an illegal opcode is handled as a NOP.
module multicycle_ctrl #(
  parameter int unsigned OPC_W       = 6,
  parameter int unsigned FUNC_W      = 5,
  parameter int unsigned ALUOP_W     = 4,
  parameter int unsigned ACK_TIMEOUT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [FUNC_W-1:0]  func,
  input  logic               INT,
  input  logic               cond_ok,
  input  logic               mem_ack,
  output logic               irLd,
  output logic [ALUOP_W-1:0] aluOp,
  output logic [2:0]         brOp,
  output logic               aluSrc,
  output logic               aluOut,
  output logic               immSel,
  output logic               mToReg,
  output logic               rdMem,
  output logic               wrMem,
  output logic               wrReg,
  output logic               updPC,
  output logic               halted,
  output logic               illegal,
  output logic               mem_err
);

  typedef enum logic [2:0] {
    StFetch, StDecode, StExec, StMem, StWb, StPcupd, StHalt
  } state_e;

  typedef enum logic [2:0] {
    ClsAlu, ClsCmov, ClsLd, ClsSt, ClsBr, ClsNop, ClsHalt
  } cls_e;

  localparam logic [OPC_W-1:0] OpcRtype   = OPC_W'(0);
  localparam logic [OPC_W-1:0] OpcImmLast = OPC_W'(15);
  localparam logic [OPC_W-1:0] OpcLui     = OPC_W'(16);
  localparam logic [OPC_W-1:0] OpcLd      = OPC_W'(17);
  localparam logic [OPC_W-1:0] OpcSt      = OPC_W'(18);
  localparam logic [OPC_W-1:0] OpcMove    = OPC_W'(20);
  localparam logic [OPC_W-1:0] OpcCmov    = OPC_W'(21);
  localparam logic [OPC_W-1:0] OpcBr      = OPC_W'(32);
  localparam logic [OPC_W-1:0] OpcBmi     = OPC_W'(33);
  localparam logic [OPC_W-1:0] OpcBpl     = OPC_W'(34);
  localparam logic [OPC_W-1:0] OpcBz      = OPC_W'(35);
  localparam logic [OPC_W-1:0] OpcHalt    = OPC_W'(36);
  localparam logic [OPC_W-1:0] OpcNop     = OPC_W'(37);
  localparam logic [OPC_W-1:0] OpcCall    = OPC_W'(38);

  localparam bit          TimeoutOn = (ACK_TIMEOUT > 0);
  localparam int unsigned CntW      = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = TimeoutOn ? CntW'(ACK_TIMEOUT - 1) : '0;

  state_e            state_q, state_d;
  cls_e              cls_q, cls_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              timeout;

  cls_e               dec_cls;
  logic               dec_illegal;
  logic [ALUOP_W-1:0] dec_aluop;
  logic [2:0]         dec_br;
  logic               dec_src, dec_out, dec_imm, dec_m;

  logic irld_d, rdmem_d, wrmem_d, wrreg_d, updpc_d, halted_d, illegal_d;

  // Instruction decode: datapath selects and instruction class from opcode/func.
  always_comb begin
    dec_cls     = ClsNop;
    dec_illegal = 1'b0;
    dec_aluop   = '0;
    dec_br      = 3'b000;
    dec_src     = 1'b0;
    dec_out     = 1'b0;
    dec_imm     = 1'b0;
    dec_m       = 1'b0;
    if (opcode == OpcRtype) begin
      dec_cls   = ClsAlu;
      dec_aluop = ALUOP_W'(func[3:0]) - ALUOP_W'(1);
      dec_src   = 1'b1;
      dec_out   = 1'b1;
    end else if (opcode <= OpcImmLast) begin
      dec_cls   = ClsAlu;
      dec_aluop = ALUOP_W'(opcode[3:0]) - ALUOP_W'(1);
    end else begin
      case (opcode)
        OpcLui: begin
          dec_cls   = ClsAlu;
          dec_aluop = '1;
        end
        OpcLd: begin
          dec_cls = ClsLd;
          dec_m   = 1'b1;
        end
        OpcSt: dec_cls = ClsSt;
        OpcMove: begin
          dec_cls = ClsAlu;
          dec_src = 1'b1;
          dec_out = 1'b1;
        end
        OpcCmov: begin
          dec_cls = ClsCmov;
          dec_src = 1'b1;
          dec_out = 1'b1;
        end
        OpcBr, OpcBmi, OpcBpl, OpcBz: begin
          dec_cls = ClsBr;
          dec_imm = 1'b1;
          dec_br  = 3'(opcode[1:0]) + 3'd1;
        end
        OpcCall: begin
          dec_cls = ClsBr;
          dec_imm = 1'b1;
          dec_br  = 3'b101;
        end
        OpcHalt: dec_cls = ClsHalt;
        OpcNop:  dec_cls = ClsNop;
        default: begin
          dec_illegal = 1'b1;
`ifdef ILLEGAL_TRAP_EN
          dec_cls = ClsHalt;
`else
          dec_cls = ClsNop;
`endif
        end
      endcase
    end
  end

  // Next state plus next values of the registered strobes (they follow the next state).
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    cnt_d   = cnt_q;
    timeout = 1'b0;
    unique case (state_q)
      // Advance only once the irLd strobe has actually been presented for a cycle.
      StFetch: if (irLd) state_d = StDecode;
      StDecode: begin
        cls_d = dec_cls;
        if (dec_cls == ClsHalt)     state_d = StHalt;
        else if (dec_cls == ClsNop) state_d = StPcupd;
        else                        state_d = StExec;
      end
      StExec: begin
        cnt_d = '0;
        if (cls_q == ClsLd || cls_q == ClsSt) state_d = StMem;
        else if (cls_q == ClsBr)              state_d = StPcupd;
        else                                  state_d = StWb;
      end
      StMem: begin
        if (mem_ack) begin
          state_d = (cls_q == ClsLd) ? StWb : StPcupd;
        end else if (TimeoutOn && cnt_q == CntMax) begin
          timeout = 1'b1;
          state_d = StPcupd;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWb:    state_d = StPcupd;
      StPcupd: state_d = StFetch;
      StHalt:  if (INT) state_d = StPcupd;
      default: state_d = StFetch;
    endcase

    irld_d    = (state_d == StFetch);
    rdmem_d   = (state_d == StMem) && (cls_d == ClsLd);
    wrmem_d   = (state_d == StMem) && (cls_d == ClsSt);
    // cond_ok is sampled on the EXEC->WB edge for CMOV.
    wrreg_d   = (state_d == StWb) && ((cls_d != ClsCmov) || cond_ok);
    updpc_d   = (state_d == StPcupd);
    halted_d  = (state_d == StHalt);
    illegal_d = (state_q == StDecode) && dec_illegal;
  end

  // State, instruction class and memory wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      cls_q   <= ClsNop;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered outputs; datapath selects are captured on DECODE exit and held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irLd    <= 1'b0;
      rdMem   <= 1'b0;
      wrMem   <= 1'b0;
      wrReg   <= 1'b0;
      updPC   <= 1'b0;
      halted  <= 1'b0;
      illegal <= 1'b0;
      mem_err <= 1'b0;
      aluOp   <= '0;
      brOp    <= 3'b000;
      aluSrc  <= 1'b0;
      aluOut  <= 1'b0;
      immSel  <= 1'b0;
      mToReg  <= 1'b0;
    end else begin
      irLd    <= irld_d;
      rdMem   <= rdmem_d;
      wrMem   <= wrmem_d;
      wrReg   <= wrreg_d;
      updPC   <= updpc_d;
      halted  <= halted_d;
      illegal <= illegal_d;
      mem_err <= timeout;
      if (state_q == StDecode) begin
        aluOp  <= dec_aluop;
        brOp   <= dec_br;
        aluSrc <= dec_src;
        aluOut <= dec_out;
        immSel <= dec_imm;
        mToReg <= dec_m;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus a randomized
// instruction stream checked against a per-instruction behavioural model.
module tb_multicycle_ctrl;

  localparam int unsigned AckTimeout = 4;
  localparam int unsigned NoAck      = 1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [4:0] func;
  logic       INT, cond_ok, mem_ack;
  logic       irLd;
  logic [3:0] aluOp;
  logic [2:0] brOp;
  logic       aluSrc, aluOut, immSel, mToReg, rdMem, wrMem, wrReg, updPC, halted, illegal, mem_err;
  logic [18:0] outs;

  assign outs = {irLd, aluOp, brOp, aluSrc, aluOut, immSel, mToReg, rdMem, wrMem, wrReg,
                 updPC, halted, illegal, mem_err};

  multicycle_ctrl #(
    .OPC_W      (6),
    .FUNC_W     (5),
    .ALUOP_W    (4),
    .ACK_TIMEOUT(AckTimeout)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .opcode  (opcode),
    .func    (func),
    .INT     (INT),
    .cond_ok (cond_ok),
    .mem_ack (mem_ack),
    .irLd    (irLd),
    .aluOp   (aluOp),
    .brOp    (brOp),
    .aluSrc  (aluSrc),
    .aluOut  (aluOut),
    .immSel  (immSel),
    .mToReg  (mToReg),
    .rdMem   (rdMem),
    .wrMem   (wrMem),
    .wrReg   (wrReg),
    .updPC   (updPC),
    .halted  (halted),
    .illegal (illegal),
    .mem_err (mem_err)
  );

  always #5 clk = ~clk;

  // Per-instruction summary: cycle counts of each strobe plus the latched selects.
  typedef struct packed {
    int unsigned lat;
    int unsigned wr;
    int unsigned rd;
    int unsigned wm;
    int unsigned upd;
    int unsigned upd_at;
    int unsigned err;
    int unsigned ill;
    int unsigned hlt;
    logic [3:0]  aluop;
    logic [2:0]  br;
    logic        src;
    logic        out;
    logic        imm;
    logic        m;
    logic        sel_stable;
  } trace_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: what one instruction should look like from FETCH to the next FETCH.
  function automatic trace_t model_instr(input logic [5:0] opc, input logic [4:0] fn,
                                         input logic cnd, input int unsigned ack_dly,
                                         input int unsigned int_dly);
    trace_t      e;
    int unsigned o, mem_cyc;
    bit          tout;
    logic [3:0]  f4, o4;
    e = '0;
    e.sel_stable = 1'b1;
    e.upd = 1;
    o  = int'(opc);
    f4 = fn[3:0];
    o4 = opc[3:0];
    mem_cyc = ack_dly + 1;
    tout = 1'b0;
    if (AckTimeout > 0 && mem_cyc > AckTimeout) begin
      mem_cyc = AckTimeout;
      tout = 1'b1;
    end
    if (o == 0) begin
      e.aluop = f4 - 4'd1; e.src = 1'b1; e.out = 1'b1; e.lat = 5; e.wr = 1;
    end else if (o <= 15) begin
      e.aluop = o4 - 4'd1; e.lat = 5; e.wr = 1;
    end else if (o == 16) begin
      e.aluop = 4'hf; e.lat = 5; e.wr = 1;
    end else if (o == 17) begin
      e.m = 1'b1; e.rd = mem_cyc; e.err = tout ? 1 : 0;
      e.wr = tout ? 0 : 1;
      e.lat = tout ? 4 + mem_cyc : 5 + mem_cyc;
    end else if (o == 18) begin
      e.wm = mem_cyc; e.err = tout ? 1 : 0; e.lat = 4 + mem_cyc;
    end else if (o == 20 || o == 21) begin
      e.src = 1'b1; e.out = 1'b1; e.lat = 5;
      e.wr = (o == 20 || cnd) ? 1 : 0;
    end else if ((o >= 32 && o <= 35) || o == 38) begin
      e.imm = 1'b1; e.lat = 4;
      case (o)
        32: e.br = 3'b001;
        33: e.br = 3'b010;
        34: e.br = 3'b011;
        35: e.br = 3'b100;
        default: e.br = 3'b101;
      endcase
    end else if (o == 36) begin
      e.hlt = int_dly + 1; e.lat = 4 + int_dly;
    end else if (o == 37) begin
      e.lat = 3;
    end else begin
      e.ill = 1;
`ifdef ILLEGAL_TRAP_EN
      e.hlt = int_dly + 1; e.lat = 4 + int_dly;
`else
      e.lat = 3;
`endif
    end
    e.upd_at = e.lat - 1;
    return e;
  endfunction

  // Drives one instruction starting from a FETCH cycle (at negedge with irLd=1), acts as
  // memory and interrupt source, and records what the DUT did until the next FETCH.
  task automatic run_instr(input logic [5:0] opc, input logic [4:0] fn, input logic cnd,
                           input int unsigned ack_dly, input int unsigned int_dly,
                           output trace_t t);
    int unsigned mem_k, halt_k;
    logic [11:0] sel0;
    t = '0;
    t.sel_stable = 1'b1;
    sel0 = '0;
    opcode = opc; func = fn; cond_ok = cnd; mem_ack = 1'b0;
    mem_k = 0; halt_k = 0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      @(negedge clk);
      if (irLd) begin
        t.lat = cyc;
        break;
      end
      if (wrReg)   t.wr++;
      if (rdMem)   t.rd++;
      if (wrMem)   t.wm++;
      if (mem_err) t.err++;
      if (illegal) t.ill++;
      if (halted)  t.hlt++;
      if (updPC) begin
        t.upd++;
        t.upd_at = cyc;
      end
      if (cyc == 2) begin
        sel0 = {aluOp, brOp, aluSrc, aluOut, immSel, mToReg};
        {t.aluop, t.br, t.src, t.out, t.imm, t.m} = sel0;
      end else if (cyc > 2 && {aluOp, brOp, aluSrc, aluOut, immSel, mToReg} !== sel0) begin
        t.sel_stable = 1'b0;
      end
      if (rdMem || wrMem) begin
        mem_ack = (mem_k == ack_dly);
        mem_k++;
      end else begin
        mem_ack = 1'b0;
      end
      // INT toggles randomly outside HALT, where it must have no effect.
      if (halted) begin
        INT = (halt_k == int_dly);
        halt_k++;
      end else begin
        INT = 1'($urandom_range(0, 1));
      end
    end
    INT = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    bit seen;
    rst_n = 1'b0; opcode = 6'd37; func = '0; INT = 1'b0; cond_ok = 1'b0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (outs !== 19'd0) $display("FAIL reset_outs: got %h want %h", outs, 19'd0);
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (irLd !== 1'b0) $display("FAIL reset_release_irld: got %b want 0", irLd);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (outs !== {1'b1, 18'd0}) $display("FAIL first_fetch: got %h want %h", outs, {1'b1, 18'd0});
    else n_pass++;
    // Abort an ADDI in the middle of its write-back.
    opcode = 6'b000101;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (wrReg) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (seen !== 1'b1) $display("FAIL addi_reaches_wb: got %b want 1", seen);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (outs !== 19'd0) $display("FAIL async_reset_wb: got %h want %h", outs, 19'd0);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outs !== {1'b1, 18'd0}) $display("FAIL refetch_after_reset: got %h want %h", outs, {1'b1, 18'd0});
    else n_pass++;
  endtask

  task automatic test_rtype;
    trace_t t, e;
    run_instr(6'b000000, 5'b00011, 1'b0, 0, 0, t);
    e = model_instr(6'b000000, 5'b00011, 1'b0, 0, 0);
    n_checks++;
    if (t !== e) $display("FAIL rtype_trace: got %p want %p", t, e);
    else n_pass++;
    n_checks++;
    if ({t.aluop, t.src, t.wr, t.upd_at, t.lat} !== {4'b0010, 1'b1, 32'd1, 32'd4, 32'd5})
      $display("FAIL rtype_fields: got aluop=%b src=%b wr=%0d upd_at=%0d lat=%0d want 0010 1 1 4 5",
               t.aluop, t.src, t.wr, t.upd_at, t.lat);
    else n_pass++;
  endtask

  task automatic test_ld;
    trace_t t, e;
    run_instr(6'b010001, 5'd0, 1'b0, 3, 0, t);
    e = model_instr(6'b010001, 5'd0, 1'b0, 3, 0);
    n_checks++;
    if (t !== e) $display("FAIL ld_trace: got %p want %p", t, e);
    else n_pass++;
    n_checks++;
    if ({t.rd, t.m, t.wr, t.err, t.lat} !== {32'd4, 1'b1, 32'd1, 32'd0, 32'd9})
      $display("FAIL ld_fields: got rd=%0d m=%b wr=%0d err=%0d lat=%0d want 4 1 1 0 9",
               t.rd, t.m, t.wr, t.err, t.lat);
    else n_pass++;
  endtask

  task automatic test_timeout;
    trace_t t, e;
    run_instr(6'b010010, 5'd0, 1'b1, NoAck, 0, t);
    e = model_instr(6'b010010, 5'd0, 1'b1, NoAck, 0);
    n_checks++;
    if (t !== e) $display("FAIL st_timeout_trace: got %p want %p", t, e);
    else n_pass++;
    n_checks++;
    if ({t.wm, t.err, t.wr, t.upd} !== {32'd4, 32'd1, 32'd0, 32'd1})
      $display("FAIL st_timeout_fields: got wm=%0d err=%0d wr=%0d upd=%0d want 4 1 0 1",
               t.wm, t.err, t.wr, t.upd);
    else n_pass++;
  endtask

  task automatic test_halt;
    trace_t t, e;
    run_instr(6'b100100, 5'd0, 1'b0, 0, 10, t);
    e = model_instr(6'b100100, 5'd0, 1'b0, 0, 10);
    n_checks++;
    if (t !== e) $display("FAIL halt_trace: got %p want %p", t, e);
    else n_pass++;
    n_checks++;
    if ({t.hlt, t.upd_at, t.lat} !== {32'd11, 32'd13, 32'd14})
      $display("FAIL halt_fields: got hlt=%0d upd_at=%0d lat=%0d want 11 13 14",
               t.hlt, t.upd_at, t.lat);
    else n_pass++;
  endtask

  task automatic test_illegal_cmov;
    trace_t t, e;
    run_instr(6'b111111, 5'd0, 1'b0, 0, 2, t);
    e = model_instr(6'b111111, 5'd0, 1'b0, 0, 2);
    n_checks++;
    if (t !== e) $display("FAIL illegal_trace: got %p want %p", t, e);
    else n_pass++;
    n_checks++;
    if (t.ill !== 1) $display("FAIL illegal_pulse: got %0d want 1", t.ill);
    else n_pass++;
    run_instr(6'b010101, 5'd0, 1'b0, 0, 0, t);
    n_checks++;
    if ({t.wr, t.lat} !== {32'd0, 32'd5})
      $display("FAIL cmov_false: got wr=%0d lat=%0d want 0 5", t.wr, t.lat);
    else n_pass++;
    run_instr(6'b010101, 5'd0, 1'b1, 0, 0, t);
    n_checks++;
    if ({t.wr, t.src, t.out} !== {32'd1, 1'b1, 1'b1})
      $display("FAIL cmov_true: got wr=%0d src=%b out=%b want 1 1 1", t.wr, t.src, t.out);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [5:0]  pool [15];
    logic [5:0]  opc;
    logic [4:0]  fn;
    logic        cnd;
    int unsigned ad, id;
    trace_t      t, e;
    pool = '{6'd0, 6'd1, 6'd9, 6'd15, 6'd16, 6'd17, 6'd18, 6'd20, 6'd21,
             6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd38};
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) opc = 6'($urandom_range(0, 63));
      else opc = pool[$urandom_range(0, 14)];
      fn  = 5'($urandom_range(0, 31));
      cnd = 1'($urandom_range(0, 1));
      ad  = ($urandom_range(0, 7) == 0) ? NoAck : $urandom_range(0, 3);
      id  = $urandom_range(0, 5);
      run_instr(opc, fn, cnd, ad, id, t);
      e = model_instr(opc, fn, cnd, ad, id);
      n_checks++;
      if (t !== e)
        $display("FAIL b2b[%0d] opc=%b fn=%b cnd=%b ack=%0d: got %p want %p",
                 i, opc, fn, cnd, ad, t, e);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_ld();
    test_timeout();
    test_halt();
    test_illegal_cmov();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
